// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the DLX pipeline hazard controller: state encoding,
// the hard-wired zero register and the default event-counter width.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_e;

    localparam int unsigned ZERO_REG          = 0;
    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/pipeline_hazard_control_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a load in EX is about to write. Register 0 never hazards.
module load_use_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_read_address1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_address2_i,
    input  logic                      id_read1_used_i,
    input  logic                      id_read2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_w_reg_addr_i,
    input  logic                      ex_w_reg_wr_en_i,
    input  logic                      ex_mem_read_i,
    output logic                      hazard_o
);

    logic src1_match;
    logic src2_match;

    assign src1_match = id_read1_used_i && (id_read_address1_i == ex_w_reg_addr_i);
    assign src2_match = id_read2_used_i && (id_read_address2_i == ex_w_reg_addr_i);

    assign hazard_o = ex_mem_read_i && ex_w_reg_wr_en_i
                   && (ex_w_reg_addr_i != REG_ADDR_WIDTH'(ZERO_REG))
                   && (src1_match || src2_match);

endmodule

// File: rtl/pipeline_hazard_control.sv
// Stall/flush sequencer for the 5-stage DLX pipeline: memory-busy freeze,
// branch/jump redirect flushes, load-use stalls and saturating event counters.
module pipeline_hazard_control
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_address1_in,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_address2_in,
    input  logic                      id_read1_used_in,
    input  logic                      id_read2_used_in,
    input  logic [REG_ADDR_WIDTH-1:0] ex_w_reg_addr_in,
    input  logic                      ex_w_reg_wr_en_in,
    input  logic                      ex_mem_read_in,
    input  logic                      branch_taken_in,
    input  logic                      jump_inst_in,
    input  logic                      mem_busy_in,
    output logic                      pc_write_en_out,
    output logic                      if_id_write_en_out,
    output logic                      if_id_flush_out,
    output logic                      id_ex_flush_out,
    output logic                      pipe_hold_out,
    output logic [CNT_WIDTH-1:0]      stall_count_out,
    output logic [CNT_WIDTH-1:0]      flush_count_out
);

    logic                 hazard;
    logic                 redirect;
    logic                 stall_evt;
    logic                 flush_evt;
    state_e               state_q, state_d;
    logic [3:0]           remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    load_use_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .id_read_address1_i (id_read_address1_in),
        .id_read_address2_i (id_read_address2_in),
        .id_read1_used_i    (id_read1_used_in),
        .id_read2_used_i    (id_read2_used_in),
        .ex_w_reg_addr_i    (ex_w_reg_addr_in),
        .ex_w_reg_wr_en_i   (ex_w_reg_wr_en_in),
        .ex_mem_read_i      (ex_mem_read_in),
        .hazard_o           (hazard)
    );

    assign redirect = branch_taken_in || jump_inst_in;

    always_comb begin
        state_d            = state_q;
        remaining_d        = remaining_q;
        pc_write_en_out    = 1'b1;
        if_id_write_en_out = 1'b1;
        if_id_flush_out    = 1'b0;
        id_ex_flush_out    = 1'b0;
        pipe_hold_out      = 1'b0;
        stall_evt          = 1'b0;
        flush_evt          = 1'b0;

        if (mem_busy_in) begin
            // Memory stall outranks everything, including pending flush cycles
            pc_write_en_out    = 1'b0;
            if_id_write_en_out = 1'b0;
            pipe_hold_out      = 1'b1;
            stall_evt          = 1'b1;
            state_d            = ST_MEM_WAIT;
        end else if (state_q == ST_FLUSH) begin
            if_id_flush_out = 1'b1;
            id_ex_flush_out = 1'b1;
            if (remaining_q <= 4'd1) begin
                state_d = ST_RUN;
            end else begin
                remaining_d = remaining_q - 4'd1;
            end
        end else begin
            // RUN, and the first MEM_WAIT cycle with memory ready, share this path
            state_d = ST_RUN;
            if (redirect) begin
                if_id_flush_out = 1'b1;
                id_ex_flush_out = 1'b1;
                flush_evt       = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    remaining_d = 4'(FLUSH_CYCLES - 1);
                end
            end else if (hazard) begin
                pc_write_en_out    = 1'b0;
                if_id_write_en_out = 1'b0;
                id_ex_flush_out    = 1'b1;
                stall_evt          = 1'b1;
            end
        end

        if (rst) begin
            pc_write_en_out    = 1'b0;
            if_id_write_en_out = 1'b0;
            if_id_flush_out    = 1'b1;
            id_ex_flush_out    = 1'b1;
            pipe_hold_out      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            remaining_q <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_count_out = stall_cnt_q;
    assign flush_count_out = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed bench for pipeline_hazard_control (FLUSH_CYCLES=3): expected
// per-cycle controls and post-edge counter values go through a scoreboard queue.
module tb_pipeline_hazard_control;

    typedef struct {
        logic [4:0] a1, a2, exa;
        logic       u1, u2, exwe, exrd, br, jmp, busy, rst;
    } in_t;

    typedef struct {
        logic [4:0] ctrl;   // {pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_hold}
        int         stall;
        int         flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  a1, a2, exa;
    logic        u1, u2, exwe, exrd, br, jmp, busy;
    logic        pc_we, ifid_we, ifid_fl, idex_fl, hold;
    logic [15:0] stall_cnt, flush_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    localparam logic [4:0] C_IDLE  = 5'b11000;
    localparam logic [4:0] C_HAZ   = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_BUSY  = 5'b00001;
    localparam logic [4:0] C_RST   = 5'b00110;

    pipeline_hazard_control #(
        .REG_ADDR_WIDTH (5),
        .FLUSH_CYCLES   (3),
        .CNT_WIDTH      (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_read_address1_in (a1),
        .id_read_address2_in (a2),
        .id_read1_used_in    (u1),
        .id_read2_used_in    (u2),
        .ex_w_reg_addr_in    (exa),
        .ex_w_reg_wr_en_in   (exwe),
        .ex_mem_read_in      (exrd),
        .branch_taken_in     (br),
        .jump_inst_in        (jmp),
        .mem_busy_in         (busy),
        .pc_write_en_out     (pc_we),
        .if_id_write_en_out  (ifid_we),
        .if_id_flush_out     (ifid_fl),
        .id_ex_flush_out     (idex_fl),
        .pipe_hold_out       (hold),
        .stall_count_out     (stall_cnt),
        .flush_count_out     (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t v;
        v.a1 = 5'd0; v.a2 = 5'd0; v.exa = 5'd0;
        v.u1 = 1'b0; v.u2 = 1'b0; v.exwe = 1'b0; v.exrd = 1'b0;
        v.br = 1'b0; v.jmp = 1'b0; v.busy = 1'b0; v.rst = 1'b0;
        return v;
    endfunction

    function automatic in_t haz();
        in_t v = idle();
        v.exrd = 1'b1; v.exwe = 1'b1; v.exa = 5'd3; v.a1 = 5'd3; v.u1 = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
    task automatic step(input string tag, input in_t v, input logic [4:0] ctrl,
                        input int st, input int fl);
        exp_t e;
        exp_t got;
        a1 = v.a1; a2 = v.a2; exa = v.exa; u1 = v.u1; u2 = v.u2;
        exwe = v.exwe; exrd = v.exrd; br = v.br; jmp = v.jmp; busy = v.busy; rst = v.rst;
        e.ctrl = ctrl; e.stall = st; e.flush = fl;
        sb.push_back(e);
        #3;
        got = sb.pop_front();
        chk({tag, ".ctrl"}, {27'd0, pc_we, ifid_we, ifid_fl, idex_fl, hold}, {27'd0, got.ctrl});
        @(posedge clk);
        #1;
        chk({tag, ".stall"}, {16'd0, stall_cnt}, got.stall);
        chk({tag, ".flush"}, {16'd0, flush_cnt}, got.flush);
    endtask

    initial begin
        in_t v;
        int  exp_st;
        v = idle(); v.rst = 1'b1;
        rst = 1'b1; a1 = '0; a2 = '0; exa = '0; u1 = 0; u2 = 0;
        exwe = 0; exrd = 0; br = 0; jmp = 0; busy = 0;
        @(posedge clk); #1;

        step("reset", v, C_RST, 0, 0);
        step("run_idle", idle(), C_IDLE, 0, 0);
        step("hazard_src1", haz(), C_HAZ, 1, 0);
        step("after_hazard", idle(), C_IDLE, 1, 0);
        v = haz(); v.exa = 5'd0; v.a1 = 5'd0;
        step("r0_no_hazard", v, C_IDLE, 1, 0);
        v = haz(); v.u1 = 1'b0;
        step("unused_src1", v, C_IDLE, 1, 0);
        v = haz(); v.a1 = 5'd9; v.a2 = 5'd7; v.u2 = 1'b1; v.exa = 5'd7;
        step("hazard_src2", v, C_HAZ, 2, 0);
        v.exwe = 1'b0;
        step("no_wr_en", v, C_IDLE, 2, 0);

        v = idle(); v.br = 1'b1;
        step("branch", v, C_FLUSH, 2, 1);
        step("flush_c2", idle(), C_FLUSH, 2, 1);
        step("flush_c3", idle(), C_FLUSH, 2, 1);
        step("flush_done", idle(), C_IDLE, 2, 1);

        v = haz(); v.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("mem_busy", v, C_BUSY, 3 + i, 1);
        end
        step("hazard_after_wait", haz(), C_HAZ, 7, 1);
        step("after_wait_idle", idle(), C_IDLE, 7, 1);

        v = haz(); v.jmp = 1'b1;
        step("jump_and_hazard", v, C_FLUSH, 7, 2);
        step("jflush_c2", idle(), C_FLUSH, 7, 2);
        step("jflush_c3", idle(), C_FLUSH, 7, 2);

        v = idle(); v.br = 1'b1;
        step("branch2", v, C_FLUSH, 7, 3);
        v = idle(); v.rst = 1'b1;
        step("rst_in_flush", v, C_RST, 0, 0);
        step("post_rst_run", idle(), C_IDLE, 0, 0);

        v = idle(); v.busy = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            exp_st = (i + 1 > 65535) ? 65535 : i + 1;
            step("saturate", v, C_BUSY, exp_st, 0);
        end
        step("sat_hold", idle(), C_IDLE, 65535, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
